// File: rtl/sdpram_ctrl_pkg.sv
// Shared types for the simple-dual-port RAM port controller.
//   sdpram_ctrl_state_e : controller state (RAM clear sweep / normal operation)
package sdpram_ctrl_pkg;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } sdpram_ctrl_state_e;

endpackage

// File: rtl/sdpram_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset (pointer back to requester 0)
//   en         : arbitration enable; no grant while low
//   req[1:0]   : request vector
//   gnt[1:0]   : one-hot or zero grant, combinational from req and the pointer
module sdpram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr_q names the requester that wins when both request.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sdpram_port_ctrl.sv
// Port controller for a simple-dual-port RAM: clears the RAM after reset or flush,
// then arbitrates two write requesters onto port A and passes reads to port B with a
// write-first bypass for same-line collisions.
//   clk, rst_n                       : clock, synchronous active-low reset
//   flush_i                          : re-clear the whole RAM
//   init_done_o                      : RAM cleared, normal operation
//   wr_req_i/wr_addr_i/wr_data_i     : two write requesters
//   wr_gnt_o                         : one-hot write grant (write accepted this cycle)
//   rd_req_i/rd_addr_i/rd_gnt_o      : line read request, address, accept
//   rd_valid_o/rd_data_o             : read line, one cycle after the grant
//   ram_we_o/ram_addr_a_o/ram_wdata_o: RAM write port
//   ram_addr_b_o/ram_rdata_i         : RAM read port (read latency 1)
module sdpram_port_ctrl
  import sdpram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_SIZE   = 1024,
  parameter int unsigned READ_MULER = 1,
  localparam int unsigned AW = $clog2(RAM_SIZE),
  localparam int unsigned BW = AW - $clog2(READ_MULER)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush_i,
  output logic                               init_done_o,
  input  logic [1:0]                         wr_req_i,
  input  logic [1:0][AW-1:0]                 wr_addr_i,
  input  logic [1:0][DATA_WIDTH-1:0]         wr_data_i,
  output logic [1:0]                         wr_gnt_o,
  input  logic                               rd_req_i,
  input  logic [BW-1:0]                      rd_addr_i,
  output logic                               rd_gnt_o,
  output logic                               rd_valid_o,
  output logic [READ_MULER*DATA_WIDTH-1:0]   rd_data_o,
  output logic                               ram_we_o,
  output logic [AW-1:0]                      ram_addr_a_o,
  output logic [DATA_WIDTH-1:0]              ram_wdata_o,
  output logic [BW-1:0]                      ram_addr_b_o,
  input  logic [READ_MULER*DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned LW = $clog2(READ_MULER);
  localparam int unsigned IW = (LW > 0) ? LW : 1;

  sdpram_ctrl_state_e state_q, state_d;
  logic [AW-1:0]      sweep_cnt_q, sweep_cnt_d;
  logic               rd_valid_q;
  logic               byp_valid_q;
  logic [IW-1:0]      byp_idx_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  logic                  in_run, arb_en, in_init;
  logic [AW-1:0]         wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  logic [BW-1:0]         wr_line;
  logic [IW-1:0]         wr_word;
  logic                  byp_hit;

  // Combinational outputs are gated with rst_n so nothing is granted or written
  // while reset is held, even before the state register has been reset.
  assign in_run  = rst_n && (state_q == StRun);
  assign in_init = rst_n && (state_q == StInit);
  assign arb_en  = in_run && !flush_i;

  sdpram_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (wr_req_i),
    .gnt   (wr_gnt_o)
  );

  assign init_done_o = in_run;
  assign rd_gnt_o    = arb_en && rd_req_i;
  assign rd_valid_o  = rst_n && rd_valid_q;
  assign ram_addr_b_o = rd_addr_i;

  assign wr_addr_sel = wr_gnt_o[1] ? wr_addr_i[1] : wr_addr_i[0];
  assign wr_data_sel = wr_gnt_o[1] ? wr_data_i[1] : wr_data_i[0];
  assign wr_line     = BW'(wr_addr_sel >> LW);
  assign wr_word     = IW'(wr_addr_sel & AW'(READ_MULER - 1));

  // Bypass does not rely on the RAM's read-during-write behaviour.
  assign byp_hit = rd_gnt_o && (|wr_gnt_o) && (wr_line == rd_addr_i);

  always_comb begin
    ram_we_o     = 1'b0;
    ram_addr_a_o = wr_addr_sel;
    ram_wdata_o  = wr_data_sel;
    if (in_init) begin
      ram_we_o     = 1'b1;
      ram_addr_a_o = sweep_cnt_q;
      ram_wdata_o  = '0;
    end else if (in_run) begin
      ram_we_o = |wr_gnt_o;
    end
  end

  always_comb begin
    rd_data_o = ram_rdata_i;
    if (byp_valid_q) begin
      rd_data_o[int'(byp_idx_q)*DATA_WIDTH +: DATA_WIDTH] = byp_data_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    case (state_q)
      StInit: begin
        if (flush_i) begin
          sweep_cnt_d = '0;
        end else if (sweep_cnt_q == AW'(RAM_SIZE - 1)) begin
          state_d     = StRun;
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + AW'(1);
        end
      end
      StRun: begin
        if (flush_i) begin
          state_d     = StInit;
          sweep_cnt_d = '0;
        end
      end
      default: begin
        state_d     = StInit;
        sweep_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StInit;
      sweep_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      byp_valid_q <= 1'b0;
      byp_idx_q   <= '0;
      byp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      rd_valid_q  <= rd_gnt_o;
      byp_valid_q <= byp_hit;
      byp_idx_q   <= wr_word;
      byp_data_q  <= wr_data_sel;
    end
  end

endmodule
